// File: rtl/axicb_slice_if.sv
// Single valid/ready/data channel bundle used on both sides of the register slice.
interface axicb_slice_if #(
  parameter int DATA_BUS_W = 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_BUS_W-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/axicb_slice.sv
// AXI channel register slice: NB_PIPELINE cascaded stages, each pass-through,
// forward register, full skid buffer or backward register depending on MODE.
module axicb_slice_stage #(
  parameter int DATA_BUS_W = 8,
  parameter int MODE       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  srst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_BUS_W-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_BUS_W-1:0] out_data,
  output logic                  busy
);
  if (MODE == 1) begin : g_fwd
    logic                  valid_q, valid_d;
    logic [DATA_BUS_W-1:0] data_q, data_d;

    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign busy      = valid_q;

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (in_ready) valid_d = in_valid;
      if (in_ready && in_valid) data_d = in_data;
      if (srst) begin
        valid_d = 1'b0;
        data_d  = '0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end
  end else if (MODE == 2) begin : g_full
    typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} state_e;
    state_e                state_q, state_d;
    logic [DATA_BUS_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
    logic                  in_acc, out_acc;

    // Main/skid valid flags are encoded in the state: BUSY = main only, FULL = both.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = m_data_q;
    assign busy      = out_valid;

    always_comb begin
      in_acc   = in_valid & in_ready;
      out_acc  = out_valid & out_ready;
      state_d  = state_q;
      m_data_d = m_data_q;
      s_data_d = s_data_q;
      unique case (state_q)
        ST_EMPTY: if (in_acc) begin
          m_data_d = in_data;
          state_d  = ST_BUSY;
        end
        ST_BUSY: begin
          if (in_acc && out_acc) begin
            m_data_d = in_data;
          end else if (in_acc) begin
            s_data_d = in_data;
            state_d  = ST_FULL;
          end else if (out_acc) begin
            state_d  = ST_EMPTY;
          end
        end
        ST_FULL: if (out_acc) begin
          m_data_d = s_data_q;
          state_d  = ST_BUSY;
        end
        default: state_d = ST_EMPTY;
      endcase
      if (srst) begin
        state_d  = ST_EMPTY;
        m_data_d = '0;
        s_data_d = '0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= ST_EMPTY;
        m_data_q <= '0;
        s_data_q <= '0;
      end else begin
        state_q  <= state_d;
        m_data_q <= m_data_d;
        s_data_q <= s_data_d;
      end
    end
  end else if (MODE == 3) begin : g_bwd
    logic                  s_valid_q, s_valid_d;
    logic [DATA_BUS_W-1:0] s_data_q, s_data_d;

    assign in_ready  = ~s_valid_q;
    assign out_valid = s_valid_q | in_valid;
    assign out_data  = s_valid_q ? s_data_q : in_data;
    assign busy      = s_valid_q;

    always_comb begin
      s_valid_d = s_valid_q;
      s_data_d  = s_data_q;
      if (in_valid && in_ready && !out_ready) begin
        s_valid_d = 1'b1;
        s_data_d  = in_data;
      end else if (s_valid_q && out_ready) begin
        s_valid_d = 1'b0;
      end
      if (srst) begin
        s_valid_d = 1'b0;
        s_data_d  = '0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_valid_q <= 1'b0;
        s_data_q  <= '0;
      end else begin
        s_valid_q <= s_valid_d;
        s_data_q  <= s_data_d;
      end
    end
  end else begin : g_wire
    assign in_ready  = out_ready;
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign busy      = 1'b0;
  end
endmodule

module axicb_slice #(
  parameter int DATA_BUS_W  = 8,
  parameter int NB_PIPELINE = 1,
  parameter int MODE        = 2
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          srst,
  axicb_slice_if.slave  i_ch,
  axicb_slice_if.master o_ch,
  output logic          o_busy
);
  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $error("axicb_slice: MODE must be 0, 1, 2 or 3");
  end else if (NB_PIPELINE == 0 || MODE == 0) begin : g_wire
    assign o_ch.valid = i_ch.valid;
    assign o_ch.data  = i_ch.data;
    assign i_ch.ready = o_ch.ready;
    assign o_busy     = 1'b0;
  end else begin : g_pipe
    logic [NB_PIPELINE:0]                 vld;
    logic [NB_PIPELINE:0]                 rdy;
    logic [NB_PIPELINE:0][DATA_BUS_W-1:0] dat;
    logic [NB_PIPELINE-1:0]               busy;

    assign vld[0]           = i_ch.valid;
    assign dat[0]           = i_ch.data;
    assign i_ch.ready       = rdy[0];
    assign o_ch.valid       = vld[NB_PIPELINE];
    assign o_ch.data        = dat[NB_PIPELINE];
    assign rdy[NB_PIPELINE] = o_ch.ready;
    assign o_busy           = |busy;

    for (genvar k = 0; k < NB_PIPELINE; k++) begin : g_stage
      axicb_slice_stage #(
        .DATA_BUS_W(DATA_BUS_W),
        .MODE      (MODE)
      ) u_stage (
        .clk      (aclk),
        .rst_n    (aresetn),
        .srst     (srst),
        .in_valid (vld[k]),
        .in_ready (rdy[k]),
        .in_data  (dat[k]),
        .out_valid(vld[k+1]),
        .out_ready(rdy[k+1]),
        .out_data (dat[k+1]),
        .busy     (busy[k])
      );
    end
  end
endmodule

// File: tb/tb_axicb_slice.sv
// Directed bench for axicb_slice: skid (MODE 2, depths 1 and 3), backward (MODE 3)
// and forward (MODE 1) variants, with sync and async reset checks.
module tb_axicb_slice;
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic srst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  axicb_slice_if #(.DATA_BUS_W(8)) a_i ();
  axicb_slice_if #(.DATA_BUS_W(8)) a_o ();
  axicb_slice_if #(.DATA_BUS_W(8)) b_i ();
  axicb_slice_if #(.DATA_BUS_W(8)) b_o ();
  axicb_slice_if #(.DATA_BUS_W(8)) c_i ();
  axicb_slice_if #(.DATA_BUS_W(8)) c_o ();
  axicb_slice_if #(.DATA_BUS_W(8)) d_i ();
  axicb_slice_if #(.DATA_BUS_W(8)) d_o ();
  logic a_busy, b_busy, c_busy, d_busy;

  axicb_slice #(.DATA_BUS_W(8), .NB_PIPELINE(1), .MODE(2)) dut_a (
    .aclk(clk), .aresetn(aresetn), .srst(srst), .i_ch(a_i), .o_ch(a_o), .o_busy(a_busy));
  axicb_slice #(.DATA_BUS_W(8), .NB_PIPELINE(3), .MODE(2)) dut_b (
    .aclk(clk), .aresetn(aresetn), .srst(srst), .i_ch(b_i), .o_ch(b_o), .o_busy(b_busy));
  axicb_slice #(.DATA_BUS_W(8), .NB_PIPELINE(1), .MODE(3)) dut_c (
    .aclk(clk), .aresetn(aresetn), .srst(srst), .i_ch(c_i), .o_ch(c_o), .o_busy(c_busy));
  axicb_slice #(.DATA_BUS_W(8), .NB_PIPELINE(1), .MODE(1)) dut_d (
    .aclk(clk), .aresetn(aresetn), .srst(srst), .i_ch(d_i), .o_ch(d_o), .o_busy(d_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          acc;
  int          e;
  logic [7:0]  q[$];
  logic [7:0]  exp_w;

  initial begin
    a_i.valid = 0; a_i.data = '0; a_o.ready = 0;
    b_i.valid = 0; b_i.data = '0; b_o.ready = 0;
    c_i.valid = 0; c_i.data = '0; c_o.ready = 0;
    d_i.valid = 0; d_i.data = '0; d_o.ready = 0;

    // reset state
    #12;
    chk("rst_a_ovalid", 32'(a_o.valid), 0);
    chk("rst_a_busy",   32'(a_busy), 0);
    chk("rst_a_odata",  32'(a_o.data), 0);
    chk("rst_a_iready", 32'(a_i.ready), 1);
    chk("rst_b_iready", 32'(b_i.ready), 1);
    chk("rst_c_iready", 32'(c_i.ready), 1);
    chk("rst_d_iready", 32'(d_i.ready), 1);
    chk("rst_d_odata",  32'(d_o.data), 0);
    tick();
    aresetn = 1;
    tick();

    // MODE 2 streaming 0x01..0x10 with o_ready high
    a_o.ready = 1;
    for (int k = 1; k <= 16; k++) begin
      a_i.valid = 1; a_i.data = 8'(k);
      #1;
      chk("stream_iready", 32'(a_i.ready), 1);
      if (k > 1) begin
        chk("stream_ovalid", 32'(a_o.valid), 1);
        chk("stream_odata",  32'(a_o.data), 32'(k - 1));
      end
      tick();
    end
    a_i.valid = 0;
    #1;
    chk("stream_last_valid", 32'(a_o.valid), 1);
    chk("stream_last_data",  32'(a_o.data), 32'h10);
    tick();
    chk("stream_empty", 32'(a_o.valid), 0);

    // MODE 2 backpressure: A1 main, A2 skid, A3 held upstream
    a_o.ready = 0;
    a_i.valid = 1; a_i.data = 8'hA1;
    tick();
    a_i.data = 8'hA2;
    #1;
    chk("bp_iready_1",  32'(a_i.ready), 1);
    chk("bp_odata_a1",  32'(a_o.data), 32'hA1);
    tick();
    a_i.data = 8'hA3;
    #1;
    chk("bp_iready_0",  32'(a_i.ready), 0);
    chk("bp_hold_a1",   32'(a_o.data), 32'hA1);
    tick();
    chk("bp_still_0",   32'(a_i.ready), 0);
    a_o.ready = 1;
    #1;
    chk("bp_out_a1",    32'(a_o.data), 32'hA1);
    tick();
    chk("bp_out_a2",    32'(a_o.data), 32'hA2);
    chk("bp_iready_up", 32'(a_i.ready), 1);
    tick();
    a_i.valid = 0;
    #1;
    chk("bp_out_a3",    32'(a_o.data), 32'hA3);
    chk("bp_out_a3_v",  32'(a_o.valid), 1);
    tick();
    chk("bp_drained",   32'(a_o.valid), 0);
    chk("bp_busy0",     32'(a_busy), 0);

    // MODE 2 x3: latency 3, capacity 6
    b_o.ready = 0;
    acc = 0;
    for (int c = 0; c < 15; c++) begin
      b_i.valid = 1; b_i.data = 8'(8'h10 + acc);
      #1;
      if (c == 1 || c == 2) chk("lat_not_yet", 32'(b_o.valid), 0);
      if (c == 3) begin
        chk("lat_valid", 32'(b_o.valid), 1);
        chk("lat_data",  32'(b_o.data), 32'h10);
      end
      if (b_i.ready) acc++;
      tick();
    end
    b_i.valid = 0;
    #1;
    chk("cap_count",  32'(acc), 6);
    chk("cap_iready", 32'(b_i.ready), 0);
    chk("cap_busy",   32'(b_busy), 1);
    b_o.ready = 1;
    e = 0;
    for (int c = 0; c < 30 && e < 6; c++) begin
      if (b_o.valid) begin
        chk("drain_order", 32'(b_o.data), 32'(8'h10 + e));
        e++;
      end
      tick();
    end
    chk("drain_count", 32'(e), 6);
    chk("drain_empty", 32'(b_busy), 0);

    // MODE 2 x3 randomized traffic against a queue scoreboard
    for (int c = 0; c < 3000; c++) begin
      b_i.valid = 1'($urandom_range(1));
      b_i.data  = 8'($urandom);
      b_o.ready = 1'($urandom_range(1));
      #1;
      if (b_o.valid && b_o.ready) begin
        chk("rand_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          exp_w = q.pop_front();
          chk("rand_data", 32'(b_o.data), 32'(exp_w));
        end
      end
      if (b_i.valid && b_i.ready) q.push_back(b_i.data);
      tick();
    end
    b_i.valid = 0; b_o.ready = 1;
    for (int c = 0; c < 40 && q.size() != 0; c++) begin
      #1;
      if (b_o.valid) begin
        exp_w = q.pop_front();
        chk("rand_drain", 32'(b_o.data), 32'(exp_w));
      end
      tick();
    end
    chk("rand_left", 32'(q.size()), 0);

    // MODE 3: zero-latency when empty, capture under backpressure
    c_o.ready = 1;
    c_i.valid = 1; c_i.data = 8'h5A;
    #1;
    chk("m3_pass_valid", 32'(c_o.valid), 1);
    chk("m3_pass_data",  32'(c_o.data), 32'h5A);
    tick();
    c_i.valid = 0;
    #1;
    chk("m3_pass_gone", 32'(c_o.valid), 0);
    c_o.ready = 0;
    c_i.valid = 1; c_i.data = 8'h5A;
    #1;
    chk("m3_ready_pre", 32'(c_i.ready), 1);
    tick();
    c_i.valid = 0; c_i.data = 8'h77;
    #1;
    chk("m3_cap_iready", 32'(c_i.ready), 0);
    chk("m3_cap_valid",  32'(c_o.valid), 1);
    chk("m3_cap_data",   32'(c_o.data), 32'h5A);
    chk("m3_cap_busy",   32'(c_busy), 1);
    tick();
    c_o.ready = 1;
    #1;
    chk("m3_release", 32'(c_o.data), 32'h5A);
    tick();
    chk("m3_after_valid", 32'(c_o.valid), 0);
    chk("m3_after_ready", 32'(c_i.ready), 1);

    // srst flush with words held in MODE 1 and MODE 2
    a_o.ready = 0; d_o.ready = 0;
    a_i.valid = 1; a_i.data = 8'h51;
    d_i.valid = 1; d_i.data = 8'hD1;
    tick();
    d_i.valid = 0;
    a_i.data = 8'h52;
    tick();
    a_i.valid = 0;
    #1;
    chk("pre_srst_a_busy",   32'(a_busy), 1);
    chk("pre_srst_a_iready", 32'(a_i.ready), 0);
    chk("pre_srst_d_iready", 32'(d_i.ready), 0);
    chk("pre_srst_d_data",   32'(d_o.data), 32'hD1);
    srst = 1;
    a_i.valid = 1; a_i.data = 8'h53; a_o.ready = 1; d_o.ready = 1;
    tick();
    srst = 0; a_i.valid = 0;
    #1;
    chk("srst_a_valid",  32'(a_o.valid), 0);
    chk("srst_a_busy",   32'(a_busy), 0);
    chk("srst_a_iready", 32'(a_i.ready), 1);
    chk("srst_a_data",   32'(a_o.data), 0);
    chk("srst_d_valid",  32'(d_o.valid), 0);
    chk("srst_d_data",   32'(d_o.data), 0);
    a_i.valid = 1; a_i.data = 8'h33;
    d_i.valid = 1; d_i.data = 8'h44;
    tick();
    a_i.valid = 0; d_i.valid = 0;
    #1;
    chk("post_srst_a", 32'(a_o.data), 32'h33);
    chk("post_srst_d", 32'(d_o.data), 32'h44);
    chk("post_srst_dv", 32'(d_o.valid), 1);
    tick();
    chk("post_srst_a_empty", 32'(a_o.valid), 0);

    // async reset mid-cycle
    a_o.ready = 0;
    a_i.valid = 1; a_i.data = 8'h99;
    tick();
    a_i.valid = 0;
    #1;
    chk("pre_arst_valid", 32'(a_o.valid), 1);
    chk("pre_arst_data",  32'(a_o.data), 32'h99);
    #2 aresetn = 0;
    #1;
    chk("arst_valid",  32'(a_o.valid), 0);
    chk("arst_busy",   32'(a_busy), 0);
    chk("arst_data",   32'(a_o.data), 0);
    chk("arst_iready", 32'(a_i.ready), 1);
    #2 aresetn = 1;
    tick();
    chk("arst_after", 32'(a_o.valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
